cbus_arbiter: RTL and testbench



---
 rtl/common.sv | 26 ++
 rtl/rr_picker.sv | 33 +++
 rtl/cbus_arbiter.sv | 146 ++++++++++++++
 tb/tb_cbus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared CBus request/response types and AXI-style burst encodings used by
// every CBus master, the arbiter and the memory/MMIO slave.
package common;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first requesting port strictly
// after the previously served one, wrapping around the port count.
module rr_picker #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         i_valid,
  input  logic [$clog2(NUM_PORTS)-1:0] i_last_idx,
  output logic [$clog2(NUM_PORTS)-1:0] o_winner,
  output logic                         o_any_valid
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_idx;

  // Walk candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    o_winner    = '0;
    o_any_valid = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_sum       = {1'b0, i_last_idx} + SUM_W'(k);
      w_idx       = (w_sum >= SUM_W'(NUM_PORTS)) ? IDX_W'(w_sum - SUM_W'(NUM_PORTS))
                                                 : IDX_W'(w_sum);
      o_winner    = i_valid[w_idx] ? w_idx : o_winner;
      o_any_valid = o_any_valid | i_valid[w_idx];
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one CBus slave port among NUM_PORTS masters.
// A grant is held for a whole burst; request and response paths are
// combinational pass-throughs to/from the selected master. Any change of the
// selected master's request while granted sets a sticky error flag.
module cbus_arbiter
  import common::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cbus_req_t                    ireqs  [NUM_PORTS],
  output cbus_resp_t                   iresps [NUM_PORTS],
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  output logic                         busy,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic                         err
);

  localparam int                IDX_W    = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_PORTS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_sel;
  logic [IDX_W-1:0] r_last_idx;
  logic             r_snap_is_write;
  logic [2:0]       r_snap_size;
  logic [31:0]      r_snap_addr;
  logic [7:0]       r_snap_len;
  logic [1:0]       r_snap_burst;
  logic             r_err;

  logic [NUM_PORTS-1:0] w_valid_vec;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_any_valid;
  logic                 w_last_beat;
  logic                 w_violation;
  cbus_req_t            w_sel_req;

  assign w_sel_req   = ireqs[r_sel];
  assign w_last_beat = oresp.ready & oresp.last;

  // Gather the per-port valid bits for the picker.
  always_comb begin
    w_valid_vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_valid_vec[i] = ireqs[i].valid;
    end
  end

  rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .i_valid     (w_valid_vec),
    .i_last_idx  (r_last_idx),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  // Next state, request/response routing and in-flight request check.
  always_comb begin
    w_state_nxt = r_state;
    oreq        = '0;
    w_violation = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      iresps[i] = '0;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        oreq          = w_sel_req;
        iresps[r_sel] = oresp;
        w_violation   = !w_sel_req.valid
                      || (w_sel_req.is_write != r_snap_is_write)
                      || (w_sel_req.size     != r_snap_size)
                      || (w_sel_req.addr     != r_snap_addr)
                      || (w_sel_req.len      != r_snap_len)
                      || (w_sel_req.burst    != r_snap_burst);
        if (w_last_beat) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant selection, rotation pointer and request snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_sel           <= '0;
      r_last_idx      <= LAST_RST;
      r_snap_is_write <= 1'b0;
      r_snap_size     <= 3'd0;
      r_snap_addr     <= 32'd0;
      r_snap_len      <= 8'd0;
      r_snap_burst    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any_valid) begin
        r_sel           <= w_winner;
        r_snap_is_write <= ireqs[w_winner].is_write;
        r_snap_size     <= ireqs[w_winner].size;
        r_snap_addr     <= ireqs[w_winner].addr;
        r_snap_len      <= ireqs[w_winner].len;
        r_snap_burst    <= ireqs[w_winner].burst;
      end
      if (r_state == ST_BUSY && w_last_beat) begin
        r_last_idx <= r_sel;
      end
    end
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_violation) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign busy      = (r_state == ST_BUSY);
  assign grant_idx = r_sel;
  assign err       = r_err;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter (3 ports). A driver steps masters, a
// slave and a transaction-level reference model once per cycle and queues the
// expected outputs; an independent monitor pops and compares them.
module tb_cbus_arbiter;
  import common::*;

  localparam int N  = 3;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  cbus_req_t     ireqs  [N];
  cbus_resp_t    iresps [N];
  cbus_req_t     oreq;
  cbus_resp_t    oresp;
  logic          busy;
  logic [IW-1:0] grant_idx;
  logic          err;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_PORTS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx),
    .err       (err)
  );

  typedef struct packed {
    logic                   chk;
    logic                   busy;
    logic [IW-1:0]          gidx;
    logic                   err;
    cbus_req_t              oreq;
    cbus_resp_t [N-1:0]     resps;
  } exp_t;

  exp_t          sb_q[$];
  logic [IW-1:0] dut_grants[$];
  int            dut_done[N];
  int            tests = 0;
  int            fails = 0;

  // environment + reference model state
  cbus_req_t p_req[N];
  bit        p_act[N];
  int        p_left[N];
  bit        m_busy, m_known, m_err;
  int        m_sel, m_last, s_beat;
  cbus_req_t m_snap;
  int        ready_pct = 100;
  bit        rst_cmd, rand_on, mod_rand;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cbus_req_t rand_req();
    cbus_req_t r;
    r.valid    = 1'b1;
    r.is_write = 1'($urandom_range(0, 1));
    r.addr     = $urandom & 32'hFFFF_FFF8;
    r.size     = 3'd3;
    r.len      = 8'($urandom_range(0, 7));
    r.burst    = AXI_BURST_INCR;
    r.data     = {$urandom, $urandom};
    r.strobe   = 8'($urandom);
    return r;
  endfunction

  // One clock of stimulus, expectation and reference-model update.
  task automatic step();
    cbus_resp_t r;
    exp_t       e;
    int         j;
    bit         won;
    @(negedge clk);
    if (rand_on) begin
      for (int i = 0; i < N; i++) begin
        if (!p_act[i] && $urandom_range(0, 3) == 0) begin
          p_act[i]  = 1'b1;
          p_req[i]  = rand_req();
          p_left[i] = int'($urandom_range(0, 2));
        end
      end
    end
    if (mod_rand && m_busy && $urandom_range(0, 199) == 0) p_req[m_sel].addr ^= 32'h8;
    for (int i = 0; i < N; i++) begin
      p_req[i].data  = {$urandom, $urandom};
      ireqs[i]       = p_req[i];
      ireqs[i].valid = p_act[i];
    end
    r.ready = ($urandom_range(0, 99) < ready_pct);
    r.data  = {$urandom, $urandom};
    if (m_busy && r.ready) r.last = (s_beat == int'(m_snap.len));
    else                   r.last = 1'($urandom_range(0, 1));
    oresp = r;
    reset = rst_cmd;

    e      = '0;
    e.chk  = m_known;
    e.busy = m_busy;
    e.gidx = IW'(m_sel);
    e.err  = m_err;
    if (m_busy) begin
      e.oreq         = ireqs[m_sel];
      e.resps[m_sel] = r;
    end
    sb_q.push_back(e);

    if (rst_cmd) begin
      m_busy = 0; m_sel = 0; m_last = N - 1; m_err = 0; m_known = 1; s_beat = 0;
      for (int i = 0; i < N; i++) begin p_act[i] = 0; p_left[i] = 0; end
    end else if (!m_busy) begin
      won = 0;
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!won && ireqs[j].valid) begin
          won = 1; m_busy = 1; m_sel = j; m_snap = ireqs[j]; s_beat = 0;
        end
      end
    end else begin
      if (ireqs[m_sel].valid !== 1'b1 || ireqs[m_sel].is_write != m_snap.is_write ||
          ireqs[m_sel].size != m_snap.size || ireqs[m_sel].addr != m_snap.addr ||
          ireqs[m_sel].len != m_snap.len || ireqs[m_sel].burst != m_snap.burst) m_err = 1;
      if (r.ready && r.last) begin
        m_busy = 0;
        m_last = m_sel;
        if (p_left[m_sel] > 0) begin
          p_left[m_sel]--;
          p_req[m_sel] = rand_req();
        end else begin
          p_act[m_sel] = 0;
        end
      end else if (r.ready) begin
        s_beat++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_cmd = 1; step(); rst_cmd = 0;
  endtask

  task automatic issue(input int port, input cbus_req_t r, input int extra);
    p_req[port] = r; p_act[port] = 1; p_left[port] = extra;
  endtask

  // Step until the DUT has delivered `target` final beats to `port`.
  task automatic run_until(input int port, input int target, input int budget, input string name);
    int n = 0;
    while (dut_done[port] < target && n < budget) begin
      step();
      n++;
    end
    tests++;
    if (dut_done[port] < target) begin
      fails++;
      $display("FAIL %s: %0d final beats seen, expected %0d within %0d cycles",
               name, dut_done[port], target, budget);
    end
  endtask

  // Scoreboard monitor: compares DUT outputs against queued expectations.
  initial begin
    exp_t e;
    logic pb = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (busy === 1'b1 && pb !== 1'b1) dut_grants.push_back(grant_idx);
      pb = busy;
      for (int i = 0; i < N; i++)
        if (iresps[i].ready === 1'b1 && iresps[i].last === 1'b1) dut_done[i]++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          chk("busy", 128'(busy), 128'(e.busy));
          chk("grant_idx", 128'(grant_idx), 128'(e.gidx));
          chk("err", 128'(err), 128'(e.err));
          chk("oreq", 128'(oreq), 128'(e.oreq));
          for (int i = 0; i < N; i++)
            chk($sformatf("iresps[%0d]", i), 128'(iresps[i]), 128'(e.resps[i]));
        end
      end
    end
  end

  initial begin
    cbus_req_t r;
    int        base;
    reset = 1'b1;
    oresp = '0;
    for (int i = 0; i < N; i++) begin
      ireqs[i] = '0; p_req[i] = '0; p_act[i] = 0; p_left[i] = 0; dut_done[i] = 0;
    end
    m_known = 0; m_busy = 0; m_sel = 0; m_last = N - 1; m_err = 0; s_beat = 0;
    rst_cmd = 1; rand_on = 0; mod_rand = 0;
    step(); step();
    rst_cmd = 0;

    // single master read, 4 beats
    ready_pct = 100;
    r = rand_req(); r.is_write = 1'b0; r.addr = 32'h8000_0000; r.len = 8'd3;
    issue(0, r, 0);
    run_until(0, dut_done[0] + 1, 50, "single_read");
    idle(3);

    // contention and 2-port fairness: 10 back-to-back transfers each
    do_reset();
    dut_grants.delete();
    ready_pct = 70;
    issue(0, rand_req(), 9);
    issue(1, rand_req(), 9);
    run_until(1, dut_done[1] + 10, 600, "fair2");
    idle(4);
    chk("fair2_count", 128'(dut_grants.size()), 128'(20));
    for (int k = 0; k < 20 && k < dut_grants.size(); k++)
      chk($sformatf("fair2_grant%0d", k), 128'(dut_grants[k]), 128'(k % 2));

    // 3-port rotation
    do_reset();
    dut_grants.delete();
    for (int i = 0; i < N; i++) issue(i, rand_req(), 5);
    run_until(2, dut_done[2] + 6, 800, "fair3");
    idle(4);
    chk("fair3_count", 128'(dut_grants.size()), 128'(18));
    for (int k = 0; k < 18 && k < dut_grants.size(); k++)
      chk($sformatf("fair3_grant%0d", k), 128'(dut_grants[k]), 128'(k % 3));

    // mid-burst address change on port 1
    do_reset();
    ready_pct = 100;
    r = rand_req(); r.is_write = 1'b0; r.addr = 32'h8000_0100; r.len = 8'd3;
    issue(1, r, 0);
    for (int n = 0; n < 10 && !m_busy; n++) step();
    step();
    p_req[1].addr = 32'h8000_0108;
    run_until(1, dut_done[1] + 1, 50, "modify");
    idle(4);
    chk("err_sticky", 128'(err), 128'(1));
    do_reset();
    idle(2);

    // reset during beat 2 of a len-7 write, then port 1 alone
    r = rand_req(); r.is_write = 1'b1; r.len = 8'd7;
    issue(0, r, 0);
    for (int n = 0; n < 10 && !m_busy; n++) step();
    step(); step();
    do_reset();
    idle(1);
    // write passthrough on port 1
    ready_pct = 60;
    r = rand_req(); r.is_write = 1'b1; r.addr = 32'h4060_0004; r.strobe = 8'hF0; r.len = 8'd3;
    issue(1, r, 0);
    run_until(1, dut_done[1] + 1, 100, "write_pass");
    idle(3);

    // randomized traffic with occasional request edits and resets
    rand_on = 1; mod_rand = 1; ready_pct = 60;
    for (int c = 0; c < 2000; c++) begin
      rst_cmd = ($urandom_range(0, 399) == 0);
      step();
    end
    rand_on = 0; mod_rand = 0; rst_cmd = 0;
    do_reset();
    idle(3);
    repeat (3) @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
